// File: rtl/axi4_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI4-Lite transaction out, one response back.
// Response waits are bounded by a timeout; responses arriving while idle are absorbed and flagged.
module axi4_lite_master_cmd #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [2:0]  PROT           = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        stray_resp,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    // Wide enough to hold TIMEOUT_CYCLES itself, so the final increment cannot wrap.
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RESPOND
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      addr_q, addr_nxt;
    logic [31:0]      wdata_nxt;
    logic             awvalid_nxt, wvalid_nxt, arvalid_nxt;
    logic             rsp_write_nxt, rsp_timeout_nxt, stray_nxt;
    logic [31:0]      rsp_data_nxt;
    logic [1:0]       rsp_resp_nxt;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESPOND);
    assign bready    = (state == IDLE) || (state == WRESP);
    assign rready    = (state == IDLE) || (state == RDATA);
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign awprot    = PROT;
    assign arprot    = PROT;
    assign wstrb     = 4'hF;

    always_comb begin
        // NOTE: every *_nxt gets a default first so no path through the case can infer a latch.
        state_nxt       = state;
        addr_nxt        = addr_q;
        wdata_nxt       = wdata;
        awvalid_nxt     = awvalid;
        wvalid_nxt      = wvalid;
        arvalid_nxt     = arvalid;
        rsp_write_nxt   = rsp_write;
        rsp_data_nxt    = rsp_data;
        rsp_resp_nxt    = rsp_resp;
        rsp_timeout_nxt = rsp_timeout;
        stray_nxt       = stray_resp;
        tmo_cnt_nxt     = tmo_cnt;

        case (state)
            IDLE: begin
                // Anything on B or R here belongs to no live transaction.
                if (bvalid || rvalid) stray_nxt = 1'b1;
                if (cmd_valid) begin
                    addr_nxt      = cmd_addr;
                    wdata_nxt     = cmd_wdata;
                    rsp_write_nxt = cmd_write;
                    if (cmd_write) begin
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = WADDR;
                    end else begin
                        arvalid_nxt = 1'b1;
                        state_nxt   = RADDR;
                    end
                end
            end
            WADDR: begin
                if (awready) awvalid_nxt = 1'b0;
                if (wready)  wvalid_nxt  = 1'b0;
                if ((!awvalid || awready) && (!wvalid || wready)) begin
                    state_nxt   = WRESP;
                    tmo_cnt_nxt = '0;
                end
            end
            WRESP: begin
                tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                if (bvalid) begin
                    rsp_resp_nxt    = bresp;
                    rsp_data_nxt    = '0;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = RESPOND;
                end else if (tmo_cnt == CNT_LAST) begin
                    rsp_resp_nxt    = 2'b10;
                    rsp_data_nxt    = '0;
                    rsp_timeout_nxt = 1'b1;
                    state_nxt       = RESPOND;
                end
            end
            RADDR: begin
                if (arready) begin
                    arvalid_nxt = 1'b0;
                    state_nxt   = RDATA;
                    tmo_cnt_nxt = '0;
                end
            end
            RDATA: begin
                tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                if (rvalid) begin
                    rsp_resp_nxt    = rresp;
                    rsp_data_nxt    = rdata;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = RESPOND;
                end else if (tmo_cnt == CNT_LAST) begin
                    rsp_resp_nxt    = 2'b10;
                    rsp_data_nxt    = '0;
                    rsp_timeout_nxt = 1'b1;
                    state_nxt       = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata       <= '0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            arvalid     <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_data    <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            stray_resp  <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            addr_q      <= addr_nxt;
            wdata       <= wdata_nxt;
            awvalid     <= awvalid_nxt;
            wvalid      <= wvalid_nxt;
            arvalid     <= arvalid_nxt;
            rsp_write   <= rsp_write_nxt;
            rsp_data    <= rsp_data_nxt;
            rsp_resp    <= rsp_resp_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            stray_resp  <= stray_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_cmd.sv
// Bench for axi4_lite_master_cmd: a cycle-stepped behavioural slave and response sink, with expected
// response fields and latency derived arithmetically from the command and the slave's chosen delays.
module tb_axi4_lite_master_cmd;

    localparam int         TMO    = 16;
    localparam logic [2:0] PROT_V = 3'b010;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, stray_resp;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_stray = 1'b0;

    always #5 clk = ~clk;

    axi4_lite_master_cmd #(.TIMEOUT_CYCLES(TMO), .PROT(PROT_V)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .stray_resp(stray_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00;
        rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
    endtask

    // One command end to end. a_dly/w_dly: extra cycles before AW(or AR)/W ready.
    // r_dly: cycles after the last address-phase handshake before B/R valid (>= TMO means timeout).
    // late: after a timeout, the slave still answers and the DUT must absorb it as a stray.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input logic [1:0] resp, input int a_dly,
                           input int w_dly, input int r_dly, input int hold, input bit late);
        bit tmo, accepted, aw_done, w_done, slv_done, consumed, seen, finished;
        int entry, exp_lat, acc_cyc, phase_cyc, cons_cyc, rv_cyc, aw_wait, w_wait, hold_cnt, viol;
        logic [1:0]  exp_resp, f_resp;
        logic [31:0] exp_data, f_data;
        logic        f_write, f_tmo;

        tmo      = (r_dly >= TMO);
        entry    = wr ? 2 + ((a_dly > w_dly) ? a_dly : w_dly) : 2 + a_dly;
        exp_lat  = tmo ? entry + TMO : entry + r_dly + 1;
        exp_resp = tmo ? 2'b10 : resp;
        exp_data = (tmo || wr) ? 32'h0 : rd;

        accepted = 0; aw_done = 0; w_done = 0; slv_done = 0; consumed = 0; seen = 0; finished = 0;
        acc_cyc = -1; phase_cyc = -1; cons_cyc = -1; rv_cyc = -1;
        aw_wait = 0; w_wait = 0; hold_cnt = 0; viol = 0;
        f_resp = 2'b00; f_data = 32'h0; f_write = 1'b0; f_tmo = 1'b0;

        for (int c = 0; c < 400 && !finished; c++) begin
            @(negedge clk);
            if (consumed && c > cons_cyc + 1 && (!late || slv_done)) begin
                finished = 1;
                idle_inputs();
            end else begin
                if (!accepted) begin
                    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
                    if (cmd_ready) begin accepted = 1; acc_cyc = c; end
                end else begin
                    cmd_valid = 1'b0;
                end

                if (accepted && c > acc_cyc) begin
                    if (!consumed && cmd_ready) viol++;
                    if (phase_cyc < 0 && (bready || rready)) viol++;
                end
                if (consumed && c == cons_cyc + 1) check("cmd_ready_after_consume", 32'(cmd_ready), 32'd1);

                // Address phase slave.
                awready = 1'b0; wready = 1'b0; arready = 1'b0;
                if (accepted && c > acc_cyc) begin
                    if (wr) begin
                        if (arvalid) viol++;
                        if (!aw_done) begin
                            if (!awvalid) viol++;
                            else if (aw_wait >= a_dly) begin
                                awready = 1'b1; aw_done = 1;
                                check("awaddr", awaddr, addr);
                                check("awprot", 32'(awprot), 32'(PROT_V));
                            end else aw_wait++;
                        end else if (awvalid) viol++;
                        if (!w_done) begin
                            if (!wvalid) viol++;
                            else if (w_wait >= w_dly) begin
                                wready = 1'b1; w_done = 1;
                                check("wdata", wdata, wd);
                                check("wstrb", 32'(wstrb), 32'hF);
                            end else w_wait++;
                        end else if (wvalid) viol++;
                        if (aw_done && w_done && phase_cyc < 0) phase_cyc = c;
                    end else begin
                        if (awvalid || wvalid) viol++;
                        if (!aw_done) begin
                            if (!arvalid) viol++;
                            else if (aw_wait >= a_dly) begin
                                arready = 1'b1; aw_done = 1; phase_cyc = c;
                                check("araddr", araddr, addr);
                                check("arprot", 32'(arprot), 32'(PROT_V));
                            end else aw_wait++;
                        end else if (arvalid) viol++;
                    end
                end

                // Response channel slave: valid held until the DUT takes it.
                bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
                if (phase_cyc >= 0 && c > phase_cyc && !slv_done && (!tmo || late)
                    && (c - phase_cyc - 1) >= r_dly) begin
                    if (wr) begin
                        bvalid = 1'b1; bresp = resp;
                        if (bready) slv_done = 1;
                    end else begin
                        rvalid = 1'b1; rresp = resp; rdata = rd;
                        if (rready) slv_done = 1;
                    end
                end

                // Response sink.
                rsp_ready = 1'b0;
                if (rsp_valid) begin
                    if (consumed || !accepted) viol++;
                    else begin
                        if (!seen) begin
                            seen = 1; rv_cyc = c;
                            f_write = rsp_write; f_resp = rsp_resp; f_data = rsp_data; f_tmo = rsp_timeout;
                            check("rsp_write", 32'(rsp_write), 32'(wr));
                            check("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
                            check("rsp_data", rsp_data, exp_data);
                            check("rsp_timeout", 32'(rsp_timeout), 32'(tmo));
                        end else if ({f_write, f_resp, f_tmo, f_data} !==
                                     {rsp_write, rsp_resp, rsp_timeout, rsp_data}) begin
                            viol++;
                        end
                        if (hold_cnt >= hold) begin
                            rsp_ready = 1'b1; consumed = 1; cons_cyc = c;
                        end else hold_cnt++;
                    end
                end
            end
        end
        if (!finished) begin
            check("txn_cycle_bound", 32'd0, 32'd1);
            idle_inputs();
        end
        if (late && tmo) exp_stray = 1'b1;
        check("stray_resp", 32'(stray_resp), 32'(exp_stray));
        check("latency", 32'(rv_cyc - acc_cyc), 32'(exp_lat));
        check("protocol", 32'(viol), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r_wr, r_late;
        logic [31:0] r_addr, r_wd, r_rd;
        logic [1:0]  r_resp;
        int          r_a, r_w, r_r, r_hold;

        idle_inputs();
        cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_valids", 32'({awvalid, wvalid, arvalid, rsp_valid}), 32'd0);
        check("reset_rsp", {rsp_write, rsp_timeout, rsp_resp, rsp_data[27:0]}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_stray", 32'(stray_resp), 32'd0);
        check("reset_readies", 32'({bready, rready}), 32'h3);
        rst = 1'b0;

        // Directed cases.
        run_txn(1, 32'h0, 32'h0000_0100, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        run_txn(1, 32'h0, 32'h0000_0100, 32'h0, 2'b00, 3, 0, 0, 0, 0);
        run_txn(1, 32'h40, 32'hCAFE_0001, 32'h0, 2'b00, 0, 4, 1, 0, 0);
        run_txn(0, 32'h124, 32'hDEAD_BEEF, 32'h0000_1A2B, 2'b00, 0, 0, 5, 0, 0);
        run_txn(0, 32'h128, 32'h0, 32'h1234_5678, 2'b00, 0, 0, TMO + 2, 0, 1);
        run_txn(1, 32'h8, 32'h5555_AAAA, 32'h0, 2'b10, 0, 0, 0, 4, 0);
        run_txn(0, 32'h10, 32'h0, 32'h0BAD_F00D, 2'b01, 1, 0, TMO - 1, 0, 0);
        run_txn(1, 32'h14, 32'h7777_0000, 32'h0, 2'b00, 0, 0, TMO, 2, 0);
        run_txn(1, 32'h18, 32'h1, 32'h0, 2'b11, 2, 0, TMO + 1, 3, 1);

        // Reset in WADDR with awvalid high and the slave stalling.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hABCD;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_reset_awvalid", 32'(awvalid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_stray = 1'b0;
        check("mid_reset_valids", 32'({awvalid, wvalid, arvalid, rsp_valid}), 32'd0);
        check("mid_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_reset_stray", 32'(stray_resp), 32'd0);
        repeat (3) @(negedge clk);
        check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = $urandom & 32'hFFFF_FFFC;
            r_wd   = $urandom;
            r_rd   = $urandom;
            r_resp = 2'($urandom_range(0, 3));
            r_a    = $urandom_range(0, 4);
            r_w    = $urandom_range(0, 4);
            r_hold = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                r_r    = TMO + $urandom_range(0, 4);
                r_late = 1'($urandom_range(0, 1));
            end else begin
                r_r    = $urandom_range(0, 6);
                r_late = 1'b0;
            end
            run_txn(r_wr, r_addr, r_wd, r_rd, r_resp, r_a, r_w, r_r, r_hold, r_late);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_cmd.md
Name: axi4_lite_master_cmd

Overview:
Single-outstanding AXI4-Lite master that turns a simple command stream (write or read, address, data) into AXI4-Lite transactions and returns one response per command. It is the initiator side that drives the LSTM register slave from a test sequencer, soft-core, or host bridge. Typical traffic is loading weights and biases, writing X_IN, and reading Y_OUT/C_OUT/VERSION. The block adds a response timeout and absorbs stray responses, so a hung or misbehaving slave cannot wedge the command stream.

Parameters:
TIMEOUT_CYCLES, 1024, number of cycles waited for bvalid/rvalid before abandoning the transaction; must be at least 1.
PROT, 3'b000, constant value driven on awprot and arprot.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  32  byte address
cmd_wdata  in  32  write data; ignored for reads
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_write  out  1  echo of cmd_write
rsp_data  out  32  rdata for reads; 0 for writes
rsp_resp  out  2  bresp/rresp; 2'b10 forced on timeout
rsp_timeout  out  1  transaction abandoned
stray_resp  out  1  sticky; set when bvalid or rvalid is accepted in IDLE
awaddr/awprot/awvalid  out  32/3/1  write address channel
awready  in  1
wdata/wstrb/wvalid  out  32/4/1  write data channel; wstrb is always 4'hF
wready  in  1
bresp  in  2;  bvalid  in  1;  bready  out  1
araddr/arprot/arvalid  out  32/3/1  read address channel
arready  in  1
rdata  in  32;  rresp  in  2;  rvalid  in  1;  rready  out  1

Behaviour:
- State machine states: IDLE, WADDR (AW and W issue phase), WRESP, RADDR, RDATA, RESPOND.
- Reset values: state=IDLE, awvalid=wvalid=arvalid=0, rsp_valid=0, rsp_timeout=0, stray_resp=0, rsp_data=0, rsp_resp=0, rsp_write=0, timeout counter=0.
- cmd_ready = (state==IDLE). On accept, cmd_addr and cmd_wdata are registered into awaddr/araddr and wdata. The next state is WADDR or RADDR.
- WADDR:
  - awvalid and wvalid both rise in the cycle after accept.
  - Each valid drops independently on its own handshake; there is no combinational ready-to-valid path.
  - Moves to WRESP in the cycle after both handshakes have completed, in either order or simultaneously.
  - Valids are never dropped before their handshake; this state has no timeout.
- RADDR: arvalid is held until arready, then moves to RDATA.
- bready = 1 in IDLE and WRESP. rready = 1 in IDLE and RDATA. Both are 0 in all other states.
- WRESP/RDATA:
  - The timeout counter clears on entry and increments every cycle.
  - A bvalid (or rvalid) handshake captures bresp (or rdata/rresp) into the rsp_* registers, with rsp_timeout=0, and moves to RESPOND.
  - If the counter reaches TIMEOUT_CYCLES-1 with no handshake: rsp_resp=2'b10, rsp_data=0, rsp_timeout=1, then RESPOND.
  - A handshake in the same cycle as expiry wins; that transaction is not a timeout.
- RESPOND: rsp_valid=1, and all rsp_* outputs stay stable until rsp_ready. Then IDLE; the next command can be accepted one cycle later.
- Stray responses: bvalid or rvalid seen in IDLE, for example a late response after a timeout, is consumed and sets stray_resp. stray_resp clears only on rst.
- Minimum write latency, with a zero-wait slave and rsp_ready=1: accept at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3.
- rst in any state returns to IDLE next cycle and drops all valids. An in-flight transaction is lost with no response.

Test Plan:
- Write cmd_addr=0x0, cmd_wdata=0x0000_0100, zero-wait slave, bresp=00 -> awvalid/wvalid high at cycle 1 only; rsp_valid at cycle 3 with rsp_write=1, rsp_resp=00, rsp_data=0.
- Same write with awready delayed 3 cycles and wready 0 cycles -> wvalid drops after cycle 1, awvalid stays high through its handshake, WRESP entered only after both handshakes, one response.
- Read cmd_addr=0x124 (Y_OUT for LAYERS=4), slave returns rdata=0x0000_1A2B after 5 wait cycles -> rsp_data=0x0000_1A2B, rsp_resp=00, rsp_timeout=0.
- TIMEOUT_CYCLES=16, read with slave never asserting rvalid -> rsp_valid 16 cycles after RDATA entry with rsp_resp=10, rsp_timeout=1. A late rvalid in IDLE is absorbed and stray_resp=1.
- Slave returns bresp=10 with rsp_ready held low 4 cycles -> rsp_valid and rsp_resp=10 remain stable for 4 cycles; cmd_ready stays 0 until the cycle after the consume.
- rst asserted while in WADDR with awvalid high -> next cycle all valids 0, state IDLE, cmd_ready=1, no rsp_valid.
